y_signature_collector: RTL
==========================

// Module: y_signature_collector
// PURPOSE
// - Downstream capture stage for the 69-bit combinational result bus y of the fuzz datapath.
// - Accepts y vectors over a valid/ready handshake and buffers them in a small FIFO.
// - Compacts each vector into a 32-bit MISR signature; flags completion after NUM_VEC vectors.
// - The final signature is the single comparable artefact per fuzz run, shared by synthesis and simulation.
// PARAMETERS
// - Y_W      69          width of the captured y bus
// - SIG_W    32          signature width; fixed by the fold function
// - DEPTH    4           FIFO entries; power of two, >= 2
// - NUM_VEC  256         vectors accepted per run, 1..65535
// PORTS
// - clk        in   1      sole clock, rising edge
// - rst        in   1      synchronous, active-high reset
// - start      in   1      one-cycle pulse; begins a run from IDLE or DONE
// - in_valid   in   1      y vector present on in_y
// - in_ready   out  1      collector can accept this cycle
// - in_y       in   Y_W    result vector from the datapath
// - busy       out  1      high in RUN and DRAIN
// - done       out  1      high in DONE; held until next start or rst
// - vec_count  out  16     vectors accepted in the current run
// - signature  out  SIG_W  current MISR value
// BEHAVIOUR
// - Reset: state IDLE; in_ready=0, busy=0, done=0, vec_count=0, signature=SEED=32'hFFFF_FFFF; FIFO empty.
// - FSM states: IDLE, RUN, DRAIN, DONE.
//   IDLE/DONE --start--> RUN. On this edge: signature=SEED, vec_count=0, FIFO cleared, done=0.
//   RUN --(accept with vec_count==NUM_VEC-1)--> DRAIN.
//   DRAIN --(FIFO empty, no pop this cycle)--> DONE.
//   start is ignored in RUN and DRAIN.
// - Handshake: in_ready = (state==RUN) && !fifo_full; registered terms only, no combinational path from in_valid.
//   An accept happens when in_valid && in_ready. It pushes in_y and increments vec_count.
//   in_y may change freely while in_ready=0.
// - Fold: f = y[31:0] ^ y[63:32] ^ {27'b0, y[68:64]}.
// - MISR step: sig' = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ f, with POLY=32'h04C1_1DB7.
// - Pop: one FIFO entry is folded per cycle whenever the FIFO is non-empty in RUN or DRAIN.
// - Latency: a vector accepted at edge N is folded into signature at edge N+1 at the earliest.
//   done rises on the edge after the last fold.
// - Full FIFO: in_ready=0. A pop in the same cycle does not reopen ready until the next cycle.
// - Simultaneous push and pop on a non-full, non-empty FIFO: both occur; occupancy is unchanged.
// - vec_count saturates at NUM_VEC; no wrap-around.
// - rst mid-run: immediate return to reset values; buffered vectors are discarded.
// CONFIGURATION
// - Macro GOLDEN_CMP_EN.
//   Defined: adds input golden[SIG_W-1:0] and output mismatch. On entry to DONE, mismatch is registered as (signature != golden). It is held through DONE and cleared on start or rst.
//   Undefined: neither port exists; the block behaves identically otherwise.
// STRUCTURE
// - Package y_sig_pkg holds: SEED, POLY, Y_W, SIG_W, the state enum sig_state_t, and the functions fold_y() and misr_step().
// - Sub-module y_sig_fifo: a synchronous DEPTH-entry FIFO with push/pop/full/empty and a clear input.
// - The top level contains the FSM, counter, MISR register and the optional comparator.
// TESTING
// - NUM_VEC=1, start, one vector y=0 -> signature=32'hFB3E_E249; done rises 2 cycles after the accept; vec_count=1.
// - in_valid held high with in_ready observed -> exactly NUM_VEC accepts; in_ready=0 from DRAIN onward; no extra push.
// - Consumer-side stall impossible: push 4 back-to-back at DEPTH=4 -> FIFO never reports full; each accepted y is folded once, in order.
// - start pulsed during RUN -> ignored; signature continuity is checked against the reference model.
// - rst asserted mid-run after 10 accepts -> next cycle busy=0, vec_count=0, signature=SEED, FIFO empty.
// - GOLDEN_CMP_EN: golden=model value -> mismatch=0; golden with bit 0 flipped -> mismatch=1 in DONE, cleared by start.

Source files
------------

// File: rtl/y_sig_pkg.sv
// Shared constants, FSM state type and MISR arithmetic for the y signature collector.
package y_sig_pkg;
  localparam int Y_W   = 69;
  localparam int SIG_W = 32;

  localparam logic [SIG_W-1:0] SEED = 32'hFFFF_FFFF;
  localparam logic [SIG_W-1:0] POLY = 32'h04C1_1DB7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sig_state_t;

  // Compress the 69-bit vector to 32 bits; the top 5 bits land in the LSBs.
  function automatic logic [SIG_W-1:0] fold_y(input logic [Y_W-1:0] y);
    return y[31:0] ^ y[63:32] ^ {27'b0, y[68:64]};
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] f);
    return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ f;
  endfunction
endpackage

// File: rtl/y_sig_fifo.sv
// Synchronous DEPTH-entry FIFO with a synchronous clear; DEPTH must be a power of two.
module y_sig_fifo #(
  parameter int W     = 69,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] pop_data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end
endmodule

// File: rtl/y_signature_collector.sv
// Captures y vectors into a FIFO and compacts them into a 32-bit MISR signature.
// Optional golden comparator enabled by defining GOLDEN_CMP_EN.
module y_signature_collector
  import y_sig_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int NUM_VEC = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Y_W-1:0]   in_y,
  output logic             busy,
  output logic             done,
  output logic [15:0]      vec_count,
  output logic [SIG_W-1:0] signature,
`ifdef GOLDEN_CMP_EN
  input  logic [SIG_W-1:0] golden,
  output logic             mismatch,
`endif
  output sig_state_t       state_dbg
);
  localparam logic [15:0] NUM_VEC_C = 16'(NUM_VEC);
  localparam logic [15:0] LAST_C    = 16'(NUM_VEC - 1);

  sig_state_t       state_q, state_d;
  logic [15:0]      count_q, count_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic             accept;
  logic             pop;
  logic             fifo_clear;
  logic             fifo_full;
  logic             fifo_empty;
  logic [Y_W-1:0]   fifo_dout;

  // Valid/ready: a vector transfers on a cycle where in_valid && in_ready; in_ready
  // depends only on registered state, and in_y is ignored while in_ready is low.
  assign in_ready = (state_q == S_RUN) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign pop      = !fifo_empty && ((state_q == S_RUN) || (state_q == S_DRAIN));

  y_sig_fifo #(
    .W     (Y_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (fifo_clear),
    .push_i      (accept),
    .push_data_i (in_y),
    .pop_i       (pop),
    .pop_data_o  (fifo_dout),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    sig_d      = sig_q;
    fifo_clear = 1'b0;
    if (pop) sig_d = misr_step(sig_q, fold_y(fifo_dout));
    if (accept && (count_q != NUM_VEC_C)) count_d = count_q + 16'd1;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_RUN;
          count_d    = '0;
          sig_d      = SEED;
          fifo_clear = 1'b1;
        end
      end
      S_RUN:   if (accept && (count_q == LAST_C)) state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      sig_q   <= SEED;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sig_q   <= sig_d;
    end
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign vec_count = count_q;
  assign signature = sig_q;
  assign state_dbg = state_q;

`ifdef GOLDEN_CMP_EN
  logic mismatch_q;

  // The signature is already final on the DRAIN->DONE edge, so it is compared there.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else if (((state_q == S_IDLE) || (state_q == S_DONE)) && start) begin
      mismatch_q <= 1'b0;
    end else if ((state_q == S_DRAIN) && (state_d == S_DONE)) begin
      mismatch_q <= (sig_q != golden);
    end
  end

  assign mismatch = mismatch_q;
`endif
endmodule
